stream_eos_merge_arbiter: RTL and testbench

Merges NUM_IN element streams into one output stream by round-robin arbitration. Each element is {data_field0 = payload, data_field1 = EOS flag}. The block sits between lowered stream producers and a single consumer port. It is sequenced by an inCtrl start token and signals completion on outCtrl. Exactly one EOS is emitted on the output, and only after every input has delivered its EOS.

---
 rtl/stream_merge_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/stream_eos_merge_arbiter.sv | 132 +++++++++++++
 tb/tb_stream_eos_merge_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_merge_pkg.sv
// rtl/stream_merge_pkg.sv - shared state encoding, default width and element layout for the EOS merge arbiter
package stream_merge_pkg;

    localparam int DEFAULT_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        EMIT_EOS = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Reference element layout at the default width; the top re-declares it at DATA_W.
    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] data_field0;
        logic                      data_field1;
    } elem_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or after ptr, cyclically
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);
    localparam int PW = $clog2(N);

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_valid && req[(int'(ptr) + k) % N]) begin
                gnt_valid                   = 1'b1;
                gnt[(int'(ptr) + k) % N]    = 1'b1;
                gnt_idx                     = PW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/stream_eos_merge_arbiter.sv
// rtl/stream_eos_merge_arbiter.sv - round-robin merge of NUM_IN EOS-terminated streams; STREAM_MERGE_TAG_EN adds source tag
module stream_eos_merge_arbiter
    import stream_merge_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NUM_IN = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       inCtrl_valid,
    output logic                       inCtrl_ready,
    input  logic [NUM_IN-1:0]          in_valid,
    output logic [NUM_IN-1:0]          in_ready,
    input  logic [NUM_IN*DATA_W-1:0]   in_data_field0,
    input  logic [NUM_IN-1:0]          in_data_field1,
    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [DATA_W-1:0]          out0_data_field0,
    output logic                       out0_data_field1,
`ifdef STREAM_MERGE_TAG_EN
    output logic [$clog2(NUM_IN)-1:0]  out0_data_field2,
`endif
    output logic                       outCtrl_valid,
    input  logic                       outCtrl_ready
);
    localparam int PW = $clog2(NUM_IN);

    typedef struct packed {
        logic [DATA_W-1:0] data_field0;
        logic              data_field1;
    } elem_w_t;

    state_t             state_q;
    logic [NUM_IN-1:0]  eos_seen_q;
    logic [PW-1:0]      rr_ptr_q;
    logic               out_valid_q;
    elem_w_t            out_q;

    logic [NUM_IN-1:0]  req;
    logic [NUM_IN-1:0]  gnt;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_any;
    logic               drain;
    logic               can_load;
    logic               xfer;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_eos;
    logic [PW-1:0]      next_ptr;

    assign drain    = out_valid_q & out0_ready;
    assign can_load = ~out_valid_q | drain;
    assign req      = (state_q == RUN) ? (in_valid & ~eos_seen_q) : '0;

    rr_arbiter #(.N(NUM_IN)) u_rr_arbiter (
        .req       (req),
        .ptr       (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_any)
    );

    // Grants only fire when the output slot is free or emptying this cycle, so drain and reload overlap.
    assign in_ready = can_load ? gnt : '0;
    assign xfer     = gnt_any & can_load;
    assign sel_data = in_data_field0[int'(gnt_idx)*DATA_W +: DATA_W];
    assign sel_eos  = in_data_field1[gnt_idx];
    assign next_ptr = (gnt_idx == PW'(NUM_IN-1)) ? '0 : gnt_idx + 1'b1;

    assign inCtrl_ready     = (state_q == IDLE);
    assign outCtrl_valid    = (state_q == DONE);
    assign out0_valid       = out_valid_q;
    assign out0_data_field0 = out_q.data_field0;
    assign out0_data_field1 = out_q.data_field1;

`ifdef STREAM_MERGE_TAG_EN
    logic [PW-1:0] tag_q;
    assign out0_data_field2 = tag_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            eos_seen_q  <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
`ifdef STREAM_MERGE_TAG_EN
            tag_q       <= '0;
`endif
        end else begin
            if (drain) out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (inCtrl_valid) begin
                        state_q    <= RUN;
                        eos_seen_q <= '0;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        rr_ptr_q <= next_ptr;
                        // Input EOS markers are absorbed; only the merged EOS leaves the block.
                        if (sel_eos) begin
                            eos_seen_q[gnt_idx] <= 1'b1;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_q       <= '{data_field0: sel_data, data_field1: 1'b0};
`ifdef STREAM_MERGE_TAG_EN
                            tag_q       <= gnt_idx;
`endif
                        end
                    end else if ((&eos_seen_q) && can_load) begin
                        state_q     <= EMIT_EOS;
                        out_valid_q <= 1'b1;
                        out_q       <= '{data_field0: '0, data_field1: 1'b1};
`ifdef STREAM_MERGE_TAG_EN
                        tag_q       <= '0;
`endif
                    end
                end
                EMIT_EOS: begin
                    if (drain) state_q <= DONE;
                end
                DONE: begin
                    if (outCtrl_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_eos_merge_arbiter.sv
// tb/tb_stream_eos_merge_arbiter.sv - directed self-checking bench for stream_eos_merge_arbiter
module tb_stream_eos_merge_arbiter;

    logic         clock;
    logic         reset;
    logic         inCtrl_valid;
    logic         inCtrl_ready;
    logic [1:0]   in_valid;
    logic [1:0]   in_ready;
    logic [127:0] in_data_field0;
    logic [1:0]   in_data_field1;
    logic         out0_valid;
    logic         out0_ready;
    logic [63:0]  out0_data_field0;
    logic         out0_data_field1;
`ifdef STREAM_MERGE_TAG_EN
    logic         out0_data_field2;
`endif
    logic         outCtrl_valid;
    logic         outCtrl_ready;

    stream_eos_merge_arbiter #(.DATA_W(64), .NUM_IN(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .inCtrl_valid     (inCtrl_valid),
        .inCtrl_ready     (inCtrl_ready),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data_field0   (in_data_field0),
        .in_data_field1   (in_data_field1),
        .out0_valid       (out0_valid),
        .out0_ready       (out0_ready),
        .out0_data_field0 (out0_data_field0),
        .out0_data_field1 (out0_data_field1),
`ifdef STREAM_MERGE_TAG_EN
        .out0_data_field2 (out0_data_field2),
`endif
        .outCtrl_valid    (outCtrl_valid),
        .outCtrl_ready    (outCtrl_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Element encoding used by the bench: {eos, payload}.
    logic [64:0] q0[$];
    logic [64:0] q1[$];
    logic [64:0] rec[$];
    int          rec_cyc[$];
    logic        rec_tag[$];
    int          done_cnt;
    int          stall_bad;

    task automatic apply_reset;
        reset          = 1'b0;
        inCtrl_valid   = 1'b0;
        in_valid       = '0;
        in_data_field0 = '0;
        in_data_field1 = '0;
        out0_ready     = 1'b0;
        outCtrl_ready  = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic do_start;
        inCtrl_valid = 1'b1;
        @(posedge clock);
        #1 inCtrl_valid = 1'b0;
    endtask

    task automatic load_scenario1;
        q0.delete();
        q1.delete();
        q0.push_back({1'b0, 64'd5});
        q0.push_back({1'b0, 64'd7});
        q0.push_back({1'b1, 64'd0});
        q1.push_back({1'b0, 64'd9});
        q1.push_back({1'b1, 64'd0});
    endtask

    // Producers/consumer stimulus: pops queues on handshake, records accepted outputs until outCtrl completes.
    task automatic run_streams(input int pat_len, input logic [3:0] pat);
        logic        have_hold;
        logic [64:0] hold_val;
        rec.delete();
        rec_cyc.delete();
        rec_tag.delete();
        done_cnt  = 0;
        stall_bad = 0;
        have_hold = 1'b0;
        hold_val  = '0;
        for (int cyc = 0; cyc < 300 && done_cnt == 0; cyc++) begin
            in_valid[0]          = (q0.size() > 0);
            in_data_field0[63:0] = (q0.size() > 0) ? q0[0][63:0] : 64'd0;
            in_data_field1[0]    = (q0.size() > 0) ? q0[0][64] : 1'b0;
            in_valid[1]            = (q1.size() > 0);
            in_data_field0[127:64] = (q1.size() > 0) ? q1[0][63:0] : 64'd0;
            in_data_field1[1]      = (q1.size() > 0) ? q1[0][64] : 1'b0;
            out0_ready    = pat[cyc % pat_len];
            outCtrl_ready = 1'b1;
            @(negedge clock);
            if (have_hold && (!out0_valid || {out0_data_field1, out0_data_field0} !== hold_val))
                stall_bad++;
            have_hold = out0_valid && !out0_ready;
            hold_val  = {out0_data_field1, out0_data_field0};
            if (out0_valid && out0_ready) begin
                rec.push_back({out0_data_field1, out0_data_field0});
                rec_cyc.push_back(cyc);
`ifdef STREAM_MERGE_TAG_EN
                rec_tag.push_back(out0_data_field2);
`else
                rec_tag.push_back(1'b0);
`endif
            end
            if (outCtrl_valid && outCtrl_ready) done_cnt++;
            if (in_valid[0] && in_ready[0]) q0.delete(0);
            if (in_valid[1] && in_ready[1]) q1.delete(0);
            @(posedge clock);
            #1;
        end
        in_valid      = '0;
        out0_ready    = 1'b0;
        outCtrl_ready = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        @(negedge clock);
        vectors++;
        if ({inCtrl_ready, in_ready, out0_valid, out0_data_field1, out0_data_field0, outCtrl_valid} !== {1'b1, 2'b00, 1'b0, 1'b0, 64'd0, 1'b0}) begin
            $display("FAIL reset_outputs: got inCtrl_ready=%b in_ready=%b out0_valid=%b f1=%b f0=%0d outCtrl_valid=%b, expected 1 00 0 0 0 0",
                     inCtrl_ready, in_ready, out0_valid, out0_data_field1, out0_data_field0, outCtrl_valid);
            miscompares++;
        end
    endtask

    task automatic test_basic_merge;
        logic [64:0] exp_v[4];
        logic        exp_t[4];
        exp_v = '{{1'b0, 64'd5}, {1'b0, 64'd9}, {1'b0, 64'd7}, {1'b1, 64'd0}};
        exp_t = '{1'b0, 1'b1, 1'b0, 1'b0};
        apply_reset();
        do_start();
        vectors++;
        if (inCtrl_ready !== 1'b0) begin
            $display("FAIL start_ready_drop: got inCtrl_ready=%b, expected 0", inCtrl_ready);
            miscompares++;
        end
        load_scenario1();
        run_streams(1, 4'b0001);
        vectors++;
        if (done_cnt !== 1 || rec.size() !== 4) begin
            $display("FAIL basic_count: got done=%0d outputs=%0d, expected 1 and 4", done_cnt, rec.size());
            miscompares++;
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= rec.size() || rec[k] !== exp_v[k]) begin
                $display("FAIL basic_elem%0d: got %h, expected %h", k, (k < rec.size()) ? rec[k] : 65'h0, exp_v[k]);
                miscompares++;
            end
`ifdef STREAM_MERGE_TAG_EN
            vectors++;
            if (k >= rec_tag.size() || rec_tag[k] !== exp_t[k]) begin
                $display("FAIL basic_tag%0d: got %b, expected %b", k, (k < rec_tag.size()) ? rec_tag[k] : 1'b0, exp_t[k]);
                miscompares++;
            end
`endif
        end
        @(negedge clock);
        vectors++;
        if (inCtrl_ready !== 1'b1 || outCtrl_valid !== 1'b0) begin
            $display("FAIL basic_back_idle: got inCtrl_ready=%b outCtrl_valid=%b, expected 1 0", inCtrl_ready, outCtrl_valid);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_d[8];
        exp_d = '{64'd100, 64'd200, 64'd101, 64'd201, 64'd102, 64'd202, 64'd103, 64'd203};
        apply_reset();
        do_start();
        for (int k = 0; k < 4; k++) begin
            q0.push_back({1'b0, 64'(100 + k)});
            q1.push_back({1'b0, 64'(200 + k)});
        end
        q0.push_back({1'b1, 64'd0});
        q1.push_back({1'b1, 64'd0});
        run_streams(1, 4'b0001);
        vectors++;
        if (done_cnt !== 1 || rec.size() !== 9) begin
            $display("FAIL b2b_count: got done=%0d outputs=%0d, expected 1 and 9", done_cnt, rec.size());
            miscompares++;
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (k >= rec.size() || rec[k] !== {1'b0, exp_d[k]}) begin
                $display("FAIL b2b_elem%0d: got %h, expected %h", k, (k < rec.size()) ? rec[k] : 65'h0, {1'b0, exp_d[k]});
                miscompares++;
            end
        end
        vectors++;
        if (rec.size() < 8 || rec_cyc[7] - rec_cyc[0] !== 7) begin
            $display("FAIL b2b_no_bubble: got span=%0d cycles for 8 elements, expected 7", (rec.size() >= 8) ? rec_cyc[7] - rec_cyc[0] : -1);
            miscompares++;
        end
    endtask

    task automatic test_stall;
        logic [64:0] exp_v[7];
        exp_v = '{{1'b0, 64'd10}, {1'b0, 64'd20}, {1'b0, 64'd11}, {1'b0, 64'd21},
                  {1'b0, 64'd12}, {1'b0, 64'd22}, {1'b1, 64'd0}};
        apply_reset();
        do_start();
        for (int k = 0; k < 3; k++) begin
            q0.push_back({1'b0, 64'(10 + k)});
            q1.push_back({1'b0, 64'(20 + k)});
        end
        q0.push_back({1'b1, 64'd0});
        q1.push_back({1'b1, 64'd0});
        run_streams(4, 4'b1001);
        vectors++;
        if (done_cnt !== 1 || rec.size() !== 7) begin
            $display("FAIL stall_count: got done=%0d outputs=%0d, expected 1 and 7", done_cnt, rec.size());
            miscompares++;
        end
        for (int k = 0; k < 7; k++) begin
            vectors++;
            if (k >= rec.size() || rec[k] !== exp_v[k]) begin
                $display("FAIL stall_elem%0d: got %h, expected %h", k, (k < rec.size()) ? rec[k] : 65'h0, exp_v[k]);
                miscompares++;
            end
        end
        vectors++;
        if (stall_bad !== 0) begin
            $display("FAIL stall_hold_stable: got %0d unstable stalled cycles, expected 0", stall_bad);
            miscompares++;
        end
    endtask

    task automatic test_early_eos;
        logic [64:0] exp_v[3];
        exp_v = '{{1'b0, 64'd1}, {1'b0, 64'd2}, {1'b1, 64'd0}};
        apply_reset();
        do_start();
        q0.push_back({1'b1, 64'd0});
        q0.push_back({1'b0, 64'd42});
        q1.push_back({1'b0, 64'd1});
        q1.push_back({1'b0, 64'd2});
        q1.push_back({1'b1, 64'd0});
        run_streams(1, 4'b0001);
        vectors++;
        if (q0.size() !== 1) begin
            $display("FAIL early_eos_blocked: got %0d in0 elements left, expected 1 (the 42 never accepted)", q0.size());
            miscompares++;
        end
        vectors++;
        if (done_cnt !== 1 || rec.size() !== 3) begin
            $display("FAIL early_eos_count: got done=%0d outputs=%0d, expected 1 and 3", done_cnt, rec.size());
            miscompares++;
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (k >= rec.size() || rec[k] !== exp_v[k]) begin
                $display("FAIL early_eos_elem%0d: got %h, expected %h", k, (k < rec.size()) ? rec[k] : 65'h0, exp_v[k]);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_midrun;
        logic [64:0] exp_v[4];
        exp_v = '{{1'b0, 64'd5}, {1'b0, 64'd9}, {1'b0, 64'd7}, {1'b1, 64'd0}};
        apply_reset();
        do_start();
        in_valid             = 2'b01;
        in_data_field0[63:0] = 64'd77;
        in_data_field1[0]    = 1'b0;
        @(posedge clock);
        #1 in_valid = '0;
        @(negedge clock);
        vectors++;
        if (out0_valid !== 1'b1 || out0_data_field0 !== 64'd77) begin
            $display("FAIL midrun_loaded: got valid=%b data=%0d, expected 1 77", out0_valid, out0_data_field0);
            miscompares++;
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({inCtrl_ready, in_ready, out0_valid, out0_data_field1, out0_data_field0, outCtrl_valid} !== {1'b1, 2'b00, 1'b0, 1'b0, 64'd0, 1'b0}) begin
            $display("FAIL midrun_async_clear: got inCtrl_ready=%b in_ready=%b out0_valid=%b f1=%b f0=%0d outCtrl_valid=%b, expected 1 00 0 0 0 0",
                     inCtrl_ready, in_ready, out0_valid, out0_data_field1, out0_data_field0, outCtrl_valid);
            miscompares++;
        end
        @(posedge clock);
        #1 reset = 1'b1;
        do_start();
        load_scenario1();
        run_streams(1, 4'b0001);
        vectors++;
        if (done_cnt !== 1 || rec.size() !== 4) begin
            $display("FAIL midrun_restart_count: got done=%0d outputs=%0d, expected 1 and 4", done_cnt, rec.size());
            miscompares++;
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= rec.size() || rec[k] !== exp_v[k]) begin
                $display("FAIL midrun_restart_elem%0d: got %h, expected %h", k, (k < rec.size()) ? rec[k] : 65'h0, exp_v[k]);
                miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_merge();
        test_back_to_back();
        test_stall();
        test_early_eos();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
